// File: rtl/syn_fifo_lvl.sv
// Single-clock FIFO with fill level, almost flags and sticky errors.
// Read port is either registered (FWFT=0) or first-word-fall-through.
module syn_fifo_lvl #(
  parameter int D_BITS = 8,
  parameter int A_BITS = 4,
  parameter int FWFT   = 0,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [D_BITS-1:0] w_data,
  input  logic              w_inc,
  input  logic              r_inc,
  input  logic              err_clr,
  output logic [D_BITS-1:0] r_data,
  output logic              w_full,
  output logic              r_empty,
  output logic              w_afull,
  output logic              r_aempty,
  output logic [A_BITS:0]   level,
  output logic              w_ovf,
  output logic              r_udf
);

  localparam int DEPTH = 1 << A_BITS;
  localparam logic [A_BITS:0] ONE  = (A_BITS+1)'(1);
  localparam logic [A_BITS:0] DPTH = (A_BITS+1)'(DEPTH);
  localparam logic [A_BITS:0] AF_L = (A_BITS+1)'(AF_LVL);
  localparam logic [A_BITS:0] AE_L = (A_BITS+1)'(AE_LVL);

  logic [D_BITS-1:0] mem [DEPTH];

  logic [A_BITS:0] wr_ptr_q, rd_ptr_q;
  logic [A_BITS:0] lvl_q, lvl_d;
  logic            full_q, empty_q;
  logic            afull_q, aempty_q;
  logic            ovf_q, udf_q;
  logic            ovf_d, udf_d;
  logic            wr_en, rd_en;

  assign wr_en = w_inc & ~full_q;
  assign rd_en = r_inc & ~empty_q;

  always_comb begin
    lvl_d = lvl_q;
    unique case ({wr_en, rd_en})
      2'b10:   lvl_d = lvl_q + ONE;
      2'b01:   lvl_d = lvl_q - ONE;
      default: lvl_d = lvl_q;
    endcase
  end

  // set has priority over clear
  assign ovf_d = (w_inc & full_q) | (ovf_q & ~err_clr);
  assign udf_d = (r_inc & empty_q) | (udf_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + ONE;
      lvl_q    <= lvl_d;
      full_q   <= (lvl_d == DPTH);
      empty_q  <= (lvl_d == '0);
      afull_q  <= (lvl_d >= AF_L);
      aempty_q <= (lvl_d <= AE_L);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr_q[A_BITS-1:0]] <= w_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign r_data = mem[rd_ptr_q[A_BITS-1:0]];
    end else begin : g_std
      logic [D_BITS-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rd_ptr_q[A_BITS-1:0]];
      end
      assign r_data = rdata_q;
    end
  endgenerate

  assign w_full   = full_q;
  assign r_empty  = empty_q;
  assign w_afull  = afull_q;
  assign r_aempty = aempty_q;
  assign level    = lvl_q;
  assign w_ovf    = ovf_q;
  assign r_udf    = udf_q;

endmodule

// File: tb/tb_syn_fifo_lvl.sv
// Bench for syn_fifo_lvl: standard and FWFT instances driven in lockstep.
// Vector table plus scoreboard of written words.
module tb_syn_fifo_lvl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, w_inc, r_inc, err_clr;
  logic [7:0] w_data;

  logic [7:0] s_rdata, f_rdata;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] s_lvl, f_lvl;

  syn_fifo_lvl #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .w_data(w_data), .w_inc(w_inc),
    .r_inc(r_inc), .err_clr(err_clr), .r_data(s_rdata),
    .w_full(s_full), .r_empty(s_empty), .w_afull(s_af),
    .r_aempty(s_ae), .level(s_lvl), .w_ovf(s_ovf), .r_udf(s_udf)
  );

  syn_fifo_lvl #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_data(w_data), .w_inc(w_inc),
    .r_inc(r_inc), .err_clr(err_clr), .r_data(f_rdata),
    .w_full(f_full), .r_empty(f_empty), .w_afull(f_af),
    .r_aempty(f_ae), .level(f_lvl), .w_ovf(f_ovf), .r_udf(f_udf)
  );

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] wd;
    int         lvl;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [33];

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] q [$];
  int         m_lvl;
  logic       m_ovf, m_udf;
  logic [7:0] m_rd;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(s_lvl), 32'(m_lvl));
    chk("w_full", 32'(s_full), 32'(m_lvl == 16));
    chk("r_empty", 32'(s_empty), 32'(m_lvl == 0));
    chk("w_afull", 32'(s_af), 32'(m_lvl >= 14));
    chk("r_aempty", 32'(s_ae), 32'(m_lvl <= 2));
    chk("w_ovf", 32'(s_ovf), 32'(m_ovf));
    chk("r_udf", 32'(s_udf), 32'(m_udf));
    chk("std_rdata", 32'(s_rdata), 32'(m_rd));
    chk("fwft_level", 32'(f_lvl), 32'(m_lvl));
    chk("fwft_empty", 32'(f_empty), 32'(m_lvl == 0));
    chk("fwft_ovf", 32'(f_ovf), 32'(m_ovf));
    if (m_lvl > 0) chk("fwft_rdata", 32'(f_rdata), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic [7:0] wd,
                      input logic r, input logic c);
    logic wa, ra;
    w_inc = w; w_data = wd; r_inc = r; err_clr = c;
    wa = w && (m_lvl < 16);
    ra = r && (m_lvl > 0);
    @(posedge clk); #1;
    if (w && m_lvl == 16) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (r && m_lvl == 0) m_udf = 1'b1;
    else if (c) m_udf = 1'b0;
    if (ra) m_rd = q.pop_front();
    if (wa) q.push_back(wd);
    m_lvl = m_lvl + int'(wa) - int'(ra);
    w_inc = 1'b0; r_inc = 1'b0; err_clr = 1'b0;
    check_all();
  endtask

  task automatic do_rst(input logic w);
    rst = 1'b1; w_inc = w; w_data = 8'hEE;
    r_inc = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; w_inc = 1'b0;
    q.delete();
    m_lvl = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rd = 8'h00;
    check_all();
  endtask

  initial begin
    rst = 1'b1; w_inc = 1'b0; r_inc = 1'b0;
    err_clr = 1'b0; w_data = 8'h00;
    m_lvl = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rd = 8'h00;

    for (int i = 0; i < 16; i++) begin
      tbl[i].w = 1'b1; tbl[i].r = 1'b0;
      tbl[i].wd = 8'(i + 1); tbl[i].lvl = i + 1;
      tbl[i].full = (i + 1 == 16); tbl[i].empty = 1'b0;
      tbl[i].af = (i + 1 >= 14); tbl[i].ae = (i + 1 <= 2);
      tbl[i].ovf = 1'b0; tbl[i].rd = 8'h00;
    end
    tbl[16].w = 1'b1; tbl[16].r = 1'b0; tbl[16].wd = 8'hAA;
    tbl[16].lvl = 16; tbl[16].full = 1'b1; tbl[16].empty = 1'b0;
    tbl[16].af = 1'b1; tbl[16].ae = 1'b0; tbl[16].ovf = 1'b1;
    tbl[16].rd = 8'h00;
    for (int i = 0; i < 16; i++) begin
      tbl[17+i].w = 1'b0; tbl[17+i].r = 1'b1; tbl[17+i].wd = 8'h00;
      tbl[17+i].lvl = 15 - i; tbl[17+i].full = 1'b0;
      tbl[17+i].empty = (15 - i == 0);
      tbl[17+i].af = (15 - i >= 14); tbl[17+i].ae = (15 - i <= 2);
      tbl[17+i].ovf = 1'b1; tbl[17+i].rd = 8'(i + 1);
    end

    do_rst(1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    for (int k = 0; k < 33; k++) begin
      step(tbl[k].w, tbl[k].wd, tbl[k].r, 1'b0);
      chk("tbl_level", 32'(s_lvl), 32'(tbl[k].lvl));
      chk("tbl_full", 32'(s_full), 32'(tbl[k].full));
      chk("tbl_empty", 32'(s_empty), 32'(tbl[k].empty));
      chk("tbl_afull", 32'(s_af), 32'(tbl[k].af));
      chk("tbl_aempty", 32'(s_ae), 32'(tbl[k].ae));
      chk("tbl_ovf", 32'(s_ovf), 32'(tbl[k].ovf));
      if (tbl[k].r) chk("tbl_rdata", 32'(s_rdata), 32'(tbl[k].rd));
    end

    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(s_ovf), 32'd0);

    for (int i = 0; i < 8; i++)
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      chk("wrap_level8", 32'(s_lvl), 32'd8);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    step(1'b1, 8'h3C, 1'b1, 1'b0);
    chk("empty_wr_level", 32'(s_lvl), 32'd1);
    chk("empty_wr_udf", 32'(s_udf), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_wr_data", 32'(s_rdata), 32'h3C);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_cleared", 32'(s_udf), 32'd0);

    do_rst(1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("fwft_fall_empty", 32'(f_empty), 32'd0);
    chk("fwft_fall_data", 32'(f_rdata), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_consumed", 32'(f_empty), 32'd1);

    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("pre_rst_level", 32'(s_lvl), 32'd5);
    do_rst(1'b1);
    chk("rst_level", 32'(s_lvl), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst_discard", 32'(s_rdata), 32'h77);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    chk("ovf_set", 32'(s_ovf), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(s_ovf), 32'd0);
    step(1'b1, 8'hCC, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(s_ovf), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hDD, 1'b1, 1'b0);
    chk("full_rw_level", 32'(s_lvl), 32'd15);
    chk("full_rw_ovf", 32'(s_ovf), 32'd1);
    chk("full_rw_data", 32'(s_rdata), 32'h80);
    while (m_lvl > 0) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
